nrisc_pc_stack: RTL and testbench
=================================

Name: nrisc_pc_stack

Overview:
Program-counter and return-address stack unit for the NRISC core. It is the responder to the CPU's PC control and STACK control outputs. It holds the PC and a hardware LIFO of return addresses for CALL, RET and RETI. It applies the increment, jump, call and return updates commanded by the control unit, one update per qualified clock.

Parameters:
ADDR_W, 16, PC and return-address width in bits
DEPTH, 8, number of return-stack entries (power of two, >=2)
RST_VECTOR, 16'h0000, PC value after reset

Ports:
clk  in  1  main clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
pc_en  in  1  update strobe; PC and stack change only on cycles with pc_en=1
pc_ctrl  in  2  PC source: 0=PC+1, 1=hold, 2=jump_addr, 3=pop stack top
stack_ctrl  in  2  0=none, 1=push PC+1, 2=pop, 3=reserved (no-op)
jump_addr  in  ADDR_W  jump/call target from ULA output
err_clr  in  1  clears sticky ovf/unf flags
pc_out  out  ADDR_W  current PC (instruction memory address)
stack_top  out  ADDR_W  entry at SP-1; 0 when empty
stack_depth  out  $clog2(DEPTH)+1  number of valid entries
stack_full  out  1  stack_depth==DEPTH
stack_empty  out  1  stack_depth==0
ovf  out  1  sticky push-on-full flag
unf  out  1  sticky pop-on-empty flag

Behaviour:
- Reset (rst=0, asynchronous): pc_out=RST_VECTOR, SP=0, ovf=0, unf=0, stack_empty=1, stack_full=0, stack_top=0. Stack RAM contents are not reset and are don't-care.
- pc_en=0: all state holds; only err_clr acts.
- pc_en=1, update rules:
  - pc_ctrl=0: PC<=PC+1, wrapping modulo 2^ADDR_W (FFFF->0000).
  - pc_ctrl=1: PC holds.
  - pc_ctrl=2: PC<=jump_addr.
  - pc_ctrl=3: if not empty, PC<=mem[SP-1]; otherwise see underflow.
- Push (stack_ctrl=1, pc_en=1): if not full, mem[SP]<=PC+1 (wrapped) and SP<=SP+1. The pushed value uses the pre-update PC. CALL is issued as stack_ctrl=1 with pc_ctrl=2 in the same strobe: return address is pushed and the jump is taken together.
- Pop (stack_ctrl=2, pc_ctrl=3, pc_en=1): PC<=mem[SP-1] and SP<=SP-1 in the same edge. This covers RET and RETI.
- Pop with pc_ctrl!=3: entry is discarded, SP decrements, and PC follows pc_ctrl.
- pc_ctrl=3 with stack_ctrl!=2: PC<=stack_top and SP is unchanged (peek jump).
- Overflow: push when full. No write, SP unchanged, ovf<=1. The PC update still executes.
- Underflow: pop or pc_ctrl=3 when empty. SP stays 0, unf<=1, PC<=PC+1.
- err_clr=1 clears ovf/unf on that edge. If a new error occurs on the same edge, the set wins.
- Latency: outputs are registered. pc_out, stack_top and stack_depth reflect an update one edge after the qualifying pc_en cycle.
- stack_top, stack_full and stack_empty are combinational from SP and mem.
- Reset asserted mid-update aborts the update. State returns to reset values immediately.

Optional Feature:
NRISC_STACK_TRAP_EN
- Defined: adds parameter TRAP_VECTOR (default 16'h0010). On an overflow or underflow event, PC<=TRAP_VECTOR instead of the normal update. SP is still unchanged.
- Undefined: errors only set the sticky flags and PC behaves as described above.

Decomposition:
- Shared package nrisc_pkg: pc_ctrl encodings (PC_INC, PC_HOLD, PC_JUMP, PC_POP) and stack_ctrl encodings (STK_NONE, STK_PUSH, STK_POP).
- Both encodings must match those emitted by the CPU control unit.
- One sub-module: nrisc_lifo, a DEPTH x ADDR_W register-array stack with push/pop/full/empty/depth outputs. nrisc_pc_stack instantiates it and adds the PC register, source mux and error logic.

Test Plan:
- Reset then 3 strobes of pc_ctrl=0 -> pc_out=0x0003, stack_empty=1, ovf=unf=0.
- PC=0x0010, CALL (stack_ctrl=1, pc_ctrl=2, jump_addr=0x0200) -> pc_out=0x0200, stack_top=0x0011, depth=1. Then RET (stack_ctrl=2, pc_ctrl=3) -> pc_out=0x0011, stack_empty=1.
- 8 nested CALLs then a 9th CALL to 0x0300 -> depth=8, stack_full=1, ovf=1, pc_out=0x0300 (0x0010 with NRISC_STACK_TRAP_EN). Then 8 RETs return addresses in reverse order.
- RET when empty at PC=0x0040 -> unf=1, pc_out=0x0041, depth=0. err_clr=1 -> unf=0.
- PC=0xFFFF, pc_ctrl=0 -> pc_out=0x0000. CALL at PC=0xFFFF -> pushed value 0x0000.
- rst driven low between clock edges mid-sequence (depth=3) -> pc_out=RST_VECTOR and stack_empty=1 immediately, without waiting for a clock edge. pc_en=0 cycles leave all state unchanged.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared NRISC control encodings for the PC source select and the
// return-stack operation. These values are the ones the CPU control
// unit emits, so they must be kept in step with that unit.
package nrisc_pkg;

    typedef enum logic [1:0] {
        PC_INC  = 2'd0,
        PC_HOLD = 2'd1,
        PC_JUMP = 2'd2,
        PC_POP  = 2'd3
    } pc_ctrl_e;

    typedef enum logic [1:0] {
        STK_NONE = 2'd0,
        STK_PUSH = 2'd1,
        STK_POP  = 2'd2,
        STK_RSVD = 2'd3
    } stk_ctrl_e;

endpackage

// File: rtl/nrisc_lifo.sv
// Return-address LIFO: DEPTH x ADDR_W register array plus stack pointer.
// Pushes on full and pops on empty are ignored here; the caller flags them.
// The top entry is presented combinationally (0 when the stack is empty).
module nrisc_lifo #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [ADDR_W-1:0]        i_wdata,
    output logic [ADDR_W-1:0]        o_top,
    output logic [$clog2(DEPTH):0]   o_depth,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_sp;

    logic [PTR_W-1:0]  w_wr_idx;
    logic [PTR_W-1:0]  w_top_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_sp == CNT_W'(DEPTH));
    assign o_empty   = (r_sp == '0);
    assign o_depth   = r_sp;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // When full the low pointer bits wrap to 0, so SP-1 still lands on DEPTH-1.
    assign w_wr_idx  = r_sp[PTR_W-1:0];
    assign w_top_idx = w_wr_idx - PTR_W'(1);
    assign o_top     = o_empty ? '0 : r_mem[w_top_idx];

    // Stack pointer: one step up on a push, one step down on a pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + 1'b1;
        end else if (w_do_pop) begin
            r_sp <= r_sp - 1'b1;
        end
    end

    // Entry storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_wdata;
        end
    end

endmodule

// File: rtl/nrisc_pc_stack.sv
// NRISC program counter and return-address stack.
// Applies INC/HOLD/JUMP/POP PC updates and PUSH/POP stack operations on
// each cycle with i_pc_en=1, and keeps sticky overflow/underflow flags.
// Build option NRISC_STACK_TRAP_EN: overflow/underflow redirect the PC to
// TRAP_VECTOR instead of the normal update.
module nrisc_pc_stack
    import nrisc_pkg::*;
#(
    parameter int                 ADDR_W     = 16,
    parameter int                 DEPTH      = 8,
    parameter logic [ADDR_W-1:0]  RST_VECTOR = '0
`ifdef NRISC_STACK_TRAP_EN
    ,
    parameter logic [ADDR_W-1:0]  TRAP_VECTOR = ADDR_W'('h10)
`endif
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_pc_en,
    input  logic [1:0]               i_pc_ctrl,
    input  logic [1:0]               i_stack_ctrl,
    input  logic [ADDR_W-1:0]        i_jump_addr,
    input  logic                     i_err_clr,
    output logic [ADDR_W-1:0]        o_pc_out,
    output logic [ADDR_W-1:0]        o_stack_top,
    output logic [$clog2(DEPTH):0]   o_stack_depth,
    output logic                     o_stack_full,
    output logic                     o_stack_empty,
    output logic                     o_ovf,
    output logic                     o_unf
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_ovf;
    logic              r_unf;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_push_req;
    logic              w_pop_req;
    logic              w_pc_pop;
    logic              w_ovf_evt;
    logic              w_unf_evt;

    assign w_pc_inc   = r_pc + 1'b1;
    assign w_push_req = i_pc_en && (stk_ctrl_e'(i_stack_ctrl) == STK_PUSH);
    assign w_pop_req  = i_pc_en && (stk_ctrl_e'(i_stack_ctrl) == STK_POP);
    assign w_pc_pop   = i_pc_en && (pc_ctrl_e'(i_pc_ctrl) == PC_POP);
    assign w_ovf_evt  = w_push_req && o_stack_full;
    assign w_unf_evt  = (w_pop_req || w_pc_pop) && o_stack_empty;

    // The LIFO itself ignores push-on-full and pop-on-empty.
    nrisc_lifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_lifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push_req),
        .i_pop   (w_pop_req),
        .i_wdata (w_pc_inc),
        .o_top   (o_stack_top),
        .o_depth (o_stack_depth),
        .o_full  (o_stack_full),
        .o_empty (o_stack_empty)
    );

    // Next-PC source select; an underflow falls through to PC+1.
    always_comb begin
        w_pc_next = r_pc;
        case (pc_ctrl_e'(i_pc_ctrl))
            PC_INC:  w_pc_next = w_pc_inc;
            PC_HOLD: w_pc_next = r_pc;
            PC_JUMP: w_pc_next = i_jump_addr;
            PC_POP:  w_pc_next = o_stack_top;
        endcase
        if (w_unf_evt) begin
            w_pc_next = w_pc_inc;
        end
`ifdef NRISC_STACK_TRAP_EN
        if (w_ovf_evt || w_unf_evt) begin
            w_pc_next = TRAP_VECTOR;
        end
`endif
    end

    // PC register: loads only on qualified strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RST_VECTOR;
        end else if (i_pc_en) begin
            r_pc <= w_pc_next;
        end
    end

    // Sticky error flags; a new error on the clearing edge wins over the clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (i_err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_evt) begin
                r_unf <= 1'b1;
            end else if (i_err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign o_pc_out = r_pc;
    assign o_ovf    = r_ovf;
    assign o_unf    = r_unf;

endmodule

// File: tb/tb_nrisc_pc_stack.sv
// Bench for nrisc_pc_stack: directed steps followed by random strobes, all
// compared against a queue-based model of the PC and return stack.
module tb_nrisc_pc_stack;

    localparam int          ADDR_W  = 16;
    localparam int          DEPTH   = 8;
    localparam logic [15:0] RST_VEC = 16'h0000;
`ifdef NRISC_STACK_TRAP_EN
    localparam bit          TRAP_ON = 1'b1;
`else
    localparam bit          TRAP_ON = 1'b0;
`endif
    localparam logic [15:0] TRAP_VEC = 16'h0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_en = 1'b0;
    logic [1:0]  pc_ctrl = 2'd0;
    logic [1:0]  stack_ctrl = 2'd0;
    logic [15:0] jump_addr = 16'h0;
    logic        err_clr = 1'b0;

    logic [15:0] pc_out;
    logic [15:0] stack_top;
    logic [3:0]  stack_depth;
    logic        stack_full;
    logic        stack_empty;
    logic        ovf;
    logic        unf;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model state
    int m_pc;
    int m_q[$];
    bit m_ovf;
    bit m_unf;

    always #5 clk = ~clk;

    nrisc_pc_stack dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pc_en       (pc_en),
        .i_pc_ctrl     (pc_ctrl),
        .i_stack_ctrl  (stack_ctrl),
        .i_jump_addr   (jump_addr),
        .i_err_clr     (err_clr),
        .o_pc_out      (pc_out),
        .o_stack_top   (stack_top),
        .o_stack_depth (stack_depth),
        .o_stack_full  (stack_full),
        .o_stack_empty (stack_empty),
        .o_ovf         (ovf),
        .o_unf         (unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc  = RST_VEC;
        m_ovf = 0;
        m_unf = 0;
    endtask

    // One clock edge of the architectural rules.
    task automatic model_step(input bit en, input int pcc, input int stk,
                              input int jmp, input bit clr);
        bit ovf_e = 0;
        bit unf_e = 0;
        int np;
        if (en) begin
            ovf_e = (stk == 1) && (m_q.size() == DEPTH);
            unf_e = ((stk == 2) || (pcc == 3)) && (m_q.size() == 0);
            case (pcc)
                0:       np = (m_pc + 1) % 65536;
                1:       np = m_pc;
                2:       np = jmp;
                default: np = (m_q.size() != 0) ? m_q[$] : 0;
            endcase
            if (unf_e) np = (m_pc + 1) % 65536;
            if (TRAP_ON && (ovf_e || unf_e)) np = TRAP_VEC;
            if (stk == 1 && !ovf_e) m_q.push_back((m_pc + 1) % 65536);
            if (stk == 2 && !unf_e) void'(m_q.pop_back());
            m_pc = np;
        end
        if (ovf_e) m_ovf = 1; else if (clr) m_ovf = 0;
        if (unf_e) m_unf = 1; else if (clr) m_unf = 0;
    endtask

    task automatic check_all(input string tag);
        int exp_top;
        exp_top = (m_q.size() != 0) ? m_q[$] : 0;
        chk({tag, ".pc"},    32'(pc_out),      32'(m_pc));
        chk({tag, ".top"},   32'(stack_top),   32'(exp_top));
        chk({tag, ".depth"}, 32'(stack_depth), 32'(m_q.size()));
        chk({tag, ".full"},  32'(stack_full),  32'(m_q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(m_q.size() == 0));
        chk({tag, ".ovf"},   32'(ovf),         32'(m_ovf));
        chk({tag, ".unf"},   32'(unf),         32'(m_unf));
    endtask

    // Apply one set of inputs across a rising edge, then check 1 time unit later.
    task automatic step(input string tag, input bit en, input int pcc, input int stk,
                        input int jmp, input bit clr);
        pc_en      = en;
        pc_ctrl    = 2'(pcc);
        stack_ctrl = 2'(stk);
        jump_addr  = 16'(jmp);
        err_clr    = clr;
        @(posedge clk);
        model_step(en, pcc, stk, jmp, clr);
        #1;
        txn++;
        $display("txn %0d %s en=%0b pc_ctrl=%0d stk=%0d jmp=%h clr=%0b -> pc=%h top=%h depth=%0d ovf=%0b unf=%0b",
                 txn, tag, en, pcc, stk, 16'(jmp), clr, pc_out, stack_top, stack_depth, ovf, unf);
        check_all(tag);
    endtask

    initial begin
        // Reset state
        model_reset();
        rst_n = 1'b0;
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Three increments from the reset vector
        for (int i = 0; i < 3; i++) step("inc", 1, 0, 0, 0, 0);
        chk("inc3.pc", 32'(pc_out), 32'h0003);

        // CALL then RET
        step("jmp10", 1, 2, 0, 16'h0010, 0);
        step("call", 1, 2, 1, 16'h0200, 0);
        chk("call.pc",  32'(pc_out), 32'h0200);
        chk("call.top", 32'(stack_top), 32'h0011);
        step("ret", 1, 3, 2, 0, 0);
        chk("ret.pc", 32'(pc_out), 32'h0011);

        // Eight nested calls, a ninth overflows, then unwind
        step("jmp10b", 1, 2, 0, 16'h0010, 0);
        for (int i = 0; i < 8; i++) step("ncall", 1, 2, 1, 16'h0100 + i * 16, 0);
        step("call9", 1, 2, 1, 16'h0300, 0);
        chk("call9.pc",    32'(pc_out), TRAP_ON ? 32'h0010 : 32'h0300);
        chk("call9.depth", 32'(stack_depth), 32'd8);
        chk("call9.ovf",   32'(ovf), 32'd1);
        for (int i = 0; i < 8; i++) step("nret", 1, 3, 2, 0, 0);
        chk("nret.last", 32'(pc_out), 32'h0011);
        step("clr_ovf", 0, 0, 0, 0, 1);

        // RET on an empty stack
        step("jmp40", 1, 2, 0, 16'h0040, 0);
        step("ret_empty", 1, 3, 2, 0, 0);
        chk("unf.pc", 32'(pc_out), TRAP_ON ? 32'h0010 : 32'h0041);
        chk("unf.flag", 32'(unf), 32'd1);
        step("clr_unf", 0, 0, 0, 0, 1);

        // PC wrap and CALL at the top of the address space
        step("jmpffff", 1, 2, 0, 16'hFFFF, 0);
        step("wrap", 1, 0, 0, 0, 0);
        chk("wrap.pc", 32'(pc_out), 32'h0000);
        step("jmpffff2", 1, 2, 0, 16'hFFFF, 0);
        step("call_wrap", 1, 2, 1, 16'h0500, 0);
        chk("call_wrap.top", 32'(stack_top), 32'h0000);

        // Idle cycles with arbitrary controls
        for (int i = 0; i < 4; i++)
            step("idle", 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 65535)), 0);

        // Asynchronous reset between edges with depth 3
        step("c1", 1, 2, 1, 16'h0600, 0);
        step("c2", 1, 2, 1, 16'h0700, 0);
        chk("pre_rst.depth", 32'(stack_depth), 32'd3);
        pc_en = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.pc", 32'(pc_out), 32'(RST_VEC));
        chk("async_rst.empty", 32'(stack_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("post_rst");

        // Random strobes against the model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 $urandom_range(0, 9) != 0,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 65535)),
                 $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
